// File: rtl/mill_rx_ctrl.sv
// ISO 14443-A 106 kb/s PCD->PICC receive controller: SOF/EOF framing around a Modified
// Miller decoder, ETU-aligned bit sampling and LSB-first byte assembly with odd parity.
module mill_rx_ctrl #(
   parameter int unsigned ETU_CLKS    = 8,
   parameter int unsigned TIMEOUT_ETU = 1024,
   parameter int unsigned NB_W        = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx_start,
   input  logic            rx_abort,
   input  logic            miller_raw,
   input  logic            dec_data,
   output logic            dec_enable,
   output logic            rx_busy,
   output logic [7:0]      rx_byte,
   output logic            rx_byte_valid,
   output logic            rx_par_err,
   output logic            rx_done,
   output logic [NB_W-1:0] rx_nbytes,
   output logic [3:0]      rx_bits,
   output logic            rx_timeout
);

   localparam int unsigned PW      = (ETU_CLKS > 1) ? $clog2(ETU_CLKS) : 1;
   localparam int unsigned TO_CLKS = TIMEOUT_ETU * ETU_CLKS;
   localparam int unsigned TW      = (TO_CLKS > 1) ? $clog2(TO_CLKS) : 1;

   localparam logic [PW-1:0] PH_LAST = PW'(ETU_CLKS - 1);
   localparam logic [PW-1:0] PH_ONE  = PW'(1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CLKS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StArmed,
      StData,
      StFlush,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic              raw_meta_q, raw_s_q, raw_prev_q;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic              pause_acc_q, pause_acc_d;
   logic              pause_etu_q, pause_etu_d;
   logic              etu_valid_q, etu_valid_d;
   logic              sof_skip_q, sof_skip_d;
   logic              prev_pend_q, prev_pend_d;
   logic              prev_bit_q, prev_bit_d;
   logic              prev_zero_q, prev_zero_d;
   logic [7:0]        sh_q, sh_d;
   logic [3:0]        nbits_q, nbits_d;
   logic [NB_W-1:0]   nbytes_q, nbytes_d;
   logic [3:0]        bits_q, bits_d;
   logic [7:0]        byte_q, byte_d;
   logic              byte_valid_q, byte_valid_d;
   logic              par_err_q, par_err_d;
   logic              timeout_q, timeout_d;

   logic pause_edge;
   logic classify;
   logic sym_y;
   logic sym_bit;
   logic eof;

   assign pause_edge = raw_prev_q & ~raw_s_q;
   assign classify   = (state_q == StData) && (phase_q == PH_ONE) && etu_valid_q && !sof_skip_q;
   assign sym_y      = ~pause_etu_q;
   assign sym_bit    = pause_etu_q & dec_data;
   assign eof        = sym_y & prev_zero_q;

   always_comb begin
      state_d      = state_q;
      to_cnt_d     = to_cnt_q;
      phase_d      = phase_q;
      pause_acc_d  = pause_acc_q;
      pause_etu_d  = pause_etu_q;
      etu_valid_d  = etu_valid_q;
      sof_skip_d   = sof_skip_q;
      prev_pend_d  = prev_pend_q;
      prev_bit_d   = prev_bit_q;
      prev_zero_d  = prev_zero_q;
      sh_d         = sh_q;
      nbits_d      = nbits_q;
      nbytes_d     = nbytes_q;
      bits_d       = bits_q;
      byte_d       = 8'h00;
      byte_valid_d = 1'b0;
      par_err_d    = 1'b0;
      timeout_d    = 1'b0;

      if (rx_abort) begin
         state_d  = StIdle;
         nbytes_d = '0;
         bits_d   = 4'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rx_start) begin
                  state_d  = StArmed;
                  to_cnt_d = '0;
                  nbytes_d = '0;
                  bits_d   = 4'd0;
               end
            end

            StArmed: begin
               if (to_cnt_q == TO_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = StIdle;
               end else if (pause_edge) begin
                  state_d     = StData;
                  phase_d     = '0;
                  pause_acc_d = 1'b0;
                  etu_valid_d = 1'b0;
                  sof_skip_d  = 1'b1;
                  prev_pend_d = 1'b0;
                  prev_zero_d = 1'b1;
                  sh_d        = 8'h00;
                  nbits_d     = 4'd0;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end

            StData: begin
               // Pause tracking uses the edge-register copy of raw_s, which lines up
               // exactly with the ETU grid started on the detected SOF edge.
               pause_acc_d = pause_acc_q | ~raw_prev_q;
               if (phase_q == PH_LAST) begin
                  phase_d     = '0;
                  pause_etu_d = pause_acc_q | ~raw_prev_q;
                  pause_acc_d = 1'b0;
                  etu_valid_d = 1'b1;
               end else begin
                  phase_d = phase_q + 1'b1;
               end

               if ((phase_q == PH_ONE) && etu_valid_q && sof_skip_q) begin
                  sof_skip_d = 1'b0;
               end

               if (classify) begin
                  if (eof) begin
                     // The pending 0 is the first half of EOF and is dropped.
                     bits_d = nbits_q;
                     if (nbits_q != 4'd0) begin
                        byte_valid_d = 1'b1;
                        byte_d       = sh_q;
                        par_err_d    = !((nbits_q == 4'd7) && (nbytes_q == '0));
                        if (nbytes_q != '1) nbytes_d = nbytes_q + 1'b1;
                        state_d = StFlush;
                     end else begin
                        state_d = StDone;
                     end
                  end else begin
                     // Data bits are released one symbol late so a trailing 0 can
                     // still be recognised as part of EOF.
                     if (prev_pend_q) begin
                        if (nbits_q == 4'd8) begin
                           byte_valid_d = 1'b1;
                           byte_d       = sh_q;
                           par_err_d    = ~^{sh_q, prev_bit_q};
                           if (nbytes_q != '1) nbytes_d = nbytes_q + 1'b1;
                           sh_d    = 8'h00;
                           nbits_d = 4'd0;
                        end else begin
                           sh_d[nbits_q[2:0]] = prev_bit_q;
                           nbits_d            = nbits_q + 4'd1;
                        end
                     end
                     prev_pend_d = 1'b1;
                     prev_bit_d  = sym_bit;
                     prev_zero_d = ~sym_bit;
                  end
               end
            end

            StFlush: state_d = StDone;

            StDone: state_d = StIdle;

            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         raw_meta_q   <= 1'b1;
         raw_s_q      <= 1'b1;
         raw_prev_q   <= 1'b1;
         to_cnt_q     <= '0;
         phase_q      <= '0;
         pause_acc_q  <= 1'b0;
         pause_etu_q  <= 1'b0;
         etu_valid_q  <= 1'b0;
         sof_skip_q   <= 1'b0;
         prev_pend_q  <= 1'b0;
         prev_bit_q   <= 1'b0;
         prev_zero_q  <= 1'b0;
         sh_q         <= 8'h00;
         nbits_q      <= 4'd0;
         nbytes_q     <= '0;
         bits_q       <= 4'd0;
         byte_q       <= 8'h00;
         byte_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         raw_meta_q   <= miller_raw;
         raw_s_q      <= raw_meta_q;
         raw_prev_q   <= raw_s_q;
         to_cnt_q     <= to_cnt_d;
         phase_q      <= phase_d;
         pause_acc_q  <= pause_acc_d;
         pause_etu_q  <= pause_etu_d;
         etu_valid_q  <= etu_valid_d;
         sof_skip_q   <= sof_skip_d;
         prev_pend_q  <= prev_pend_d;
         prev_bit_q   <= prev_bit_d;
         prev_zero_q  <= prev_zero_d;
         sh_q         <= sh_d;
         nbits_q      <= nbits_d;
         nbytes_q     <= nbytes_d;
         bits_q       <= bits_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         par_err_q    <= par_err_d;
         timeout_q    <= timeout_d;
      end
   end

   assign dec_enable    = (state_q == StData);
   assign rx_busy       = (state_q == StArmed) || (state_q == StData);
   assign rx_byte       = byte_q;
   assign rx_byte_valid = byte_valid_q;
   assign rx_par_err    = par_err_q;
   assign rx_done       = (state_q == StDone);
   assign rx_nbytes     = nbytes_q;
   assign rx_bits       = bits_q;
   assign rx_timeout    = timeout_q;

endmodule

// File: tb/tb_mill_rx_ctrl.sv
// Bench for mill_rx_ctrl: Modified Miller frame encoder, frame table with a byte/done
// scoreboard, plus timeout, abort and mid-frame reset sequences.
module tb_mill_rx_ctrl;

   localparam int ETU     = 8;
   localparam int TO_ETU  = 1024;
   localparam int NBW     = 6;
   localparam int TO_CLKS = TO_ETU * ETU;
   localparam int SYM_Y   = 0;
   localparam int SYM_X   = 1;
   localparam int SYM_Z   = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rx_start = 1'b0;
   logic           rx_abort = 1'b0;
   logic           miller_raw = 1'b1;
   logic           dec_data = 1'b0;
   logic           dec_enable;
   logic           rx_busy;
   logic [7:0]     rx_byte;
   logic           rx_byte_valid;
   logic           rx_par_err;
   logic           rx_done;
   logic [NBW-1:0] rx_nbytes;
   logic [3:0]     rx_bits;
   logic           rx_timeout;

   always #5 clk = ~clk;

   mill_rx_ctrl #(
      .ETU_CLKS   (ETU),
      .TIMEOUT_ETU(TO_ETU),
      .NB_W       (NBW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_start     (rx_start),
      .rx_abort     (rx_abort),
      .miller_raw   (miller_raw),
      .dec_data     (dec_data),
      .dec_enable   (dec_enable),
      .rx_busy      (rx_busy),
      .rx_byte      (rx_byte),
      .rx_byte_valid(rx_byte_valid),
      .rx_par_err   (rx_par_err),
      .rx_done      (rx_done),
      .rx_nbytes    (rx_nbytes),
      .rx_bits      (rx_bits),
      .rx_timeout   (rx_timeout)
   );

   typedef struct {logic [7:0] b; logic e;} strobe_t;
   typedef struct {logic [NBW-1:0] nb; logic [3:0] bits;} done_t;
   typedef struct {int n; logic [63:0] bits; int exp_nb; int exp_rb;} vec_t;

   strobe_t sq[$];
   done_t   dq[$];
   int      n_vec = 0;
   int      n_fail = 0;
   int      done_cnt = 0;
   int      to_cnt = 0;
   bit      timeout_ok = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({dec_enable, rx_busy, rx_byte, rx_byte_valid, rx_par_err, rx_done,
                  rx_nbytes, rx_bits, rx_timeout});
   endfunction

   // Reference: 9-bit groups are byte+parity, remainder is a residual byte.
   task automatic expect_frame(input logic [63:0] bits, input int n);
      strobe_t s;
      done_t   d;
      int      nb = 0;
      int      i = 0;
      int      rem;
      while (i + 9 <= n) begin
         s.b = bits[i+:8];
         s.e = ~^{bits[i+:8], bits[i+8]};
         sq.push_back(s);
         nb++;
         i += 9;
      end
      rem = n - i;
      if (rem > 0) begin
         s.b = 8'h00;
         for (int j = 0; j < rem; j++) s.b[j] = bits[i+j];
         s.e = !(rem == 7 && nb == 0);
         sq.push_back(s);
         nb++;
      end
      d.nb   = NBW'(nb);
      d.bits = 4'(rem);
      dq.push_back(d);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_byte_valid) begin
            if (sq.size() == 0) begin
               check("unexpected_strobe", 32'(rx_byte_valid), 32'd0);
            end else begin
               strobe_t s;
               s = sq.pop_front();
               check("strobe_byte", 32'(rx_byte), 32'(s.b));
               check("strobe_par_err", 32'(rx_par_err), 32'(s.e));
            end
         end
         if (rx_done) begin
            done_cnt++;
            if (dq.size() == 0) begin
               check("unexpected_done", 32'(rx_done), 32'd0);
            end else begin
               done_t d;
               d = dq.pop_front();
               check("done_nbytes", 32'(rx_nbytes), 32'(d.nb));
               check("done_bits", 32'(rx_bits), 32'(d.bits));
               check("done_dec_enable", 32'(dec_enable), 32'd0);
            end
         end
         if (rx_timeout) begin
            to_cnt++;
            if (!timeout_ok) check("unexpected_timeout", 32'(rx_timeout), 32'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_rx();
      rx_start = 1'b1;
      @(posedge clk);
      #1;
      rx_start = 1'b0;
      check("start_busy", 32'(rx_busy), 32'd1);
      check("start_clears_counts", 32'({rx_nbytes, rx_bits}), 32'd0);
   endtask

   // Drives SOF, the data bits, EOF and two idle ETUs; dec_data lags the line by one ETU.
   task automatic send_frame(input logic [63:0] bits, input int n, input int abort_at,
                             input int rst_at);
      int   sym[80];
      logic dd[80];
      int   ns;
      logic prevb;
      bit   pz;
      sym[0] = SYM_Z;
      prevb  = 1'b0;
      for (int i = 0; i < n; i++) begin
         sym[i+1] = bits[i] ? SYM_X : (prevb ? SYM_Y : SYM_Z);
         prevb    = bits[i];
      end
      sym[n+1] = prevb ? SYM_Y : SYM_Z;
      sym[n+2] = SYM_Y;
      sym[n+3] = SYM_Y;
      sym[n+4] = SYM_Y;
      ns = n + 5;
      dd[0] = 1'b0;
      for (int k = 1; k < ns; k++) dd[k] = (sym[k-1] == SYM_X);
      for (int k = 0; k < ns; k++) begin
         for (int o = 0; o < ETU; o++) begin
            int c;
            c = k * ETU + o;
            @(posedge clk);
            #1;
            if (rx_abort) begin
               rx_abort = 1'b0;
               check("abort_idle", 32'({dec_enable, rx_busy, rx_done, rx_nbytes}), 32'd0);
               miller_raw = 1'b1;
               dec_data   = 1'b0;
               return;
            end
            if (rst) begin
               check("midframe_rst_outputs", outs(), 32'd0);
               rst        = 1'b0;
               miller_raw = 1'b1;
               dec_data   = 1'b0;
               return;
            end
            if (c == 2) check("sof_latency_pre", 32'(dec_enable), 32'd0);
            if (c == 3) check("sof_latency", 32'(dec_enable), 32'd1);
            if (c == abort_at) rx_abort = 1'b1;
            if (c == rst_at) rst = 1'b1;
            pz = (sym[k] == SYM_Z && o < 2) || (sym[k] == SYM_X && o >= ETU/2 && o < ETU/2 + 2);
            miller_raw = !pz;
            dec_data   = dd[k];
         end
      end
      miller_raw = 1'b1;
      dec_data   = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t    tbl[9];
      strobe_t s;
      int      prev;
      int      t0;
      int      seen;
      bit      dec_hi;

      tbl[0] = '{n: 7,  bits: 64'h26,   exp_nb: 1, exp_rb: 7};  // REQA short frame
      tbl[1] = '{n: 18, bits: 64'h4193, exp_nb: 2, exp_rb: 0};  // 0x93/1, 0x20/0
      tbl[2] = '{n: 9,  bits: 64'h093,  exp_nb: 1, exp_rb: 0};  // 0x93 bad parity
      tbl[3] = '{n: 18, bits: 64'h4093, exp_nb: 2, exp_rb: 0};  // bad parity then good
      tbl[4] = '{n: 0,  bits: 64'h0,    exp_nb: 0, exp_rb: 0};  // empty frame
      tbl[5] = '{n: 4,  bits: 64'hD,    exp_nb: 1, exp_rb: 4};  // residual nibble
      tbl[6] = '{n: 8,  bits: 64'hFF,   exp_nb: 1, exp_rb: 8};  // byte without parity
      tbl[7] = '{n: 16, bits: 64'hABA5, exp_nb: 2, exp_rb: 7};  // 7 bits after a byte
      tbl[8] = '{n: 9,  bits: 64'h100,  exp_nb: 1, exp_rb: 0};  // 0x00 good parity

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", outs(), 32'd0);
      rst = 1'b0;
      idle(3);

      for (int v = 0; v < 9; v++) begin
         expect_frame(tbl[v].bits, tbl[v].n);
         start_rx();
         idle(2);
         prev = done_cnt;
         send_frame(tbl[v].bits, tbl[v].n, -1, -1);
         check("done_count", 32'(done_cnt - prev), 32'd1);
         check("hold_nbytes", 32'(rx_nbytes), 32'(tbl[v].exp_nb));
         check("hold_bits", 32'(rx_bits), 32'(tbl[v].exp_rb));
         check("queues_drained", 32'(sq.size() + dq.size()), 32'd0);
         idle(4);
      end

      // Timeout with the line idle.
      timeout_ok = 1'b1;
      t0     = to_cnt;
      prev   = done_cnt;
      seen   = -1;
      dec_hi = 1'b0;
      start_rx();
      for (int k = 1; k <= TO_CLKS + 20; k++) begin
         @(posedge clk);
         #1;
         if (dec_enable || rx_done) dec_hi = 1'b1;
         if (rx_timeout && seen < 0) seen = k;
      end
      check("timeout_cycle", 32'(seen), 32'(TO_CLKS));
      check("timeout_pulses", 32'(to_cnt - t0), 32'd1);
      check("timeout_no_done_dec", 32'({dec_hi, 1'b0}) | 32'(done_cnt - prev), 32'd0);
      check("timeout_not_busy", 32'(rx_busy), 32'd0);
      timeout_ok = 1'b0;

      // Abort and start together: abort wins.
      rx_start = 1'b1;
      rx_abort = 1'b1;
      @(posedge clk);
      #1;
      rx_start = 1'b0;
      rx_abort = 1'b0;
      check("abort_beats_start", 32'(rx_busy), 32'd0);
      idle(3);

      // Abort during the second byte of SELECT.
      s.b = 8'h93;
      s.e = 1'b0;
      sq.push_back(s);
      prev = done_cnt;
      start_rx();
      idle(2);
      send_frame(64'h4193, 18, 114, -1);
      idle(60);
      check("abort_no_done", 32'(done_cnt - prev), 32'd0);
      check("abort_strobes", 32'(sq.size()), 32'd0);

      // Reset mid-frame, then a clean REQA.
      prev = done_cnt;
      start_rx();
      idle(2);
      send_frame(64'h26, 7, -1, 40);
      idle(20);
      check("rst_no_done", 32'(done_cnt - prev), 32'd0);
      check("rst_no_strobe", 32'(sq.size()), 32'd0);
      expect_frame(64'h26, 7);
      start_rx();
      idle(2);
      send_frame(64'h26, 7, -1, -1);
      check("post_rst_done", 32'(done_cnt - prev), 32'd1);
      check("post_rst_nbytes", 32'(rx_nbytes), 32'd1);
      check("post_rst_bits", 32'(rx_bits), 32'd7);
      check("post_rst_drained", 32'(sq.size() + dq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mill_rx_ctrl.md
# mill_rx_ctrl

Receive-side controller for the ISO 14443-A PCD→PICC path at 106 kb/s. It arms on request, detects Start-of-Frame on the synchronized pause envelope, and enables the Modified Miller decoder aligned to the ETU grid. It samples the decoder's NRZ-L output once per ETU, detects End-of-Frame from the raw line, and assembles LSB-first bytes with odd-parity checking and short-frame (7-bit) support. It sits between the analog pause detector / Miller decoder and the frame layer (CRC_A, command parser).

## Interface
- ETU_CLKS, 8, clocks per ETU (fc/16 clock); must be even, ≥4
- TIMEOUT_ETU, 1024, ETUs allowed from arm to SOF
- NB_W, 6, width of byte counter (max 2^NB_W−1 bytes/frame)

- clk  in  1  fc/16 clock (847.5 kHz); all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rx_start  in  1  one-cycle pulse; arms reception (ignored unless IDLE)
- rx_abort  in  1  one-cycle pulse; returns to IDLE from any state, no rx_done
- miller_raw  in  1  async pause envelope, 0 = pause
- dec_data  in  1  decoder NRZ-L output
- dec_enable  out  1  decoder enable (its active-low clear when 0)
- rx_busy  out  1  high in ARMED, DATA
- rx_byte  out  8  received byte, LSB = first bit on air
- rx_byte_valid  out  1  one-cycle strobe qualifying rx_byte, rx_par_err
- rx_par_err  out  1  parity fail for the strobed byte
- rx_done  out  1  one-cycle pulse at end of frame
- rx_nbytes  out  NB_W  bytes strobed in the frame; valid with rx_done
- rx_bits  out  4  residual bits in last strobed byte (0 = byte-aligned); valid with rx_done
- rx_timeout  out  1  one-cycle pulse; no SOF within TIMEOUT_ETU

## Operation
- miller_raw passes a 2-flop synchronizer → raw_s; pause edge = raw_s 1→0 vs. previous cycle.
- States: IDLE → (rx_start) ARMED → (pause edge) DATA → (EOF) DONE → IDLE; ARMED → (timeout) IDLE.
- ARMED: ETU counter runs for timeout; reaching TIMEOUT_ETU·ETU_CLKS cycles pulses rx_timeout and returns to IDLE.
- DATA entry: phase counter p (0..ETU_CLKS−1) cleared; dec_enable=1. The SOF ETU is consumed and not output.
- Per ETU, controller records pause_seen (raw_s==0 any cycle of the ETU). At p==1 of the following ETU it samples dec_data = bit of the completed ETU.
- Symbol classification: pause_seen==0 → Y. Otherwise symbol = sampled dec_data (1 = X, 0 = Z).
- EOF: a Y when the previous symbol was 0 (Y or Z, SOF counts as Z). That previous 0 belongs to EOF and is discarded. Every other symbol is a data bit.
- Assembly: bits shift into positions 0..7 then parity; on the 9th bit strobe rx_byte_valid with rx_par_err = ~^(byte, parity). rx_nbytes increments (saturates at max).
- At EOF, residual n=bits held (0..8):
  - n=7 with rx_nbytes==0 (short frame): strobe byte with bit7=0, par_err=0.
  - Other n>0: strobe with unfilled bits 0 and par_err=1.
  - rx_bits=n.
- DONE: rx_done one cycle, dec_enable=0, return to IDLE.
- rx_abort or rst mid-frame: no strobe, no rx_done; all outputs to reset values next cycle.

## Timing
- Reset/IDLE values: dec_enable=0, rx_busy=0, rx_byte=0, rx_byte_valid=0, rx_par_err=0, rx_done=0, rx_nbytes=0, rx_bits=0, rx_timeout=0. rx_nbytes and rx_bits hold their values from rx_done until the next rx_start.
- raw-to-SOF latency: pause on miller_raw → dec_enable high 3 cycles later (2 sync + 1 edge register).
- Byte strobe: cycle after p==1 sampling of the parity bit.
- rx_done: 1 cycle after any residual strobe, else 1 cycle after EOF classification.
- rx_start and rx_abort in the same cycle: abort wins.
- A pause edge in the same cycle as timeout expiry: timeout wins.

## Test plan
- Short frame REQA 0x26: SOF, bits 0,1,1,0,0,1,0, EOF → one strobe rx_byte=0x26, par_err=0, rx_done with nbytes=1, bits=7.
- SELECT 0x93 + parity 1, then 0x20 + parity 0 → strobes 0x93/0, 0x20/0; rx_done nbytes=2, bits=0.
- 0x93 with parity 0 → rx_par_err=1 on that strobe; frame continues; rx_done nbytes=1.
- rx_start with miller_raw held 1 for TIMEOUT_ETU·8 cycles → rx_timeout pulse; rx_done stays 0; dec_enable stays 0.
- rx_abort mid-second byte → no further strobes; rx_done stays 0; dec_enable=0 next cycle.
- rst asserted during DATA, then new rx_start and REQA frame → clean reception identical to the first scenario.
